// File: rtl/game_turn_ctl.sv
// Two-player ship game flow: mouse-to-cell mapping, placement, peer sync, AIM/SEND/RESULT/WAIT turns, hit counting, win/lose.
// All outputs registered, 1 cycle after the triggering input (pick_ship 2 after button rise); shot_valid/shot_cell held until shot_ready.
module game_turn_ctl #(
  parameter int GRID_X0        = 608,
  parameter int GRID_Y0        = 193,
  parameter int CELL_LOG2      = 5,
  parameter int GRID_N         = 10,
  parameter int SHIP_CELLS     = 11,
  parameter int EXTRA_TURN     = 0,
  parameter int TIMEOUT_FRAMES = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        first_player,
  input  logic        restart,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic [7:0]  ship_count,
  input  logic        peer_ready,
  input  logic        shot_ready,
  input  logic        res_valid,
  input  logic        res_hit,
  input  logic        enemy_valid,
  input  logic [7:0]  enemy_cell,
  input  logic        enemy_hit,
  output logic [7:0]  mouse_cell,
  output logic        cell_valid,
  output logic        pick_ship,
  output logic        local_ready,
  output logic        aim_en,
  output logic        shot_valid,
  output logic [7:0]  shot_cell,
  output logic [7:0]  my_hits,
  output logic [7:0]  their_hits,
  output logic        win,
  output logic        lose,
  output logic [3:0]  state_led
);

  localparam int         GRID_PIX = GRID_N << CELL_LOG2;
  localparam logic [7:0] PASS     = 8'hFF;

  typedef enum logic [2:0] {
    S_PLACE, S_SYNC, S_AIM, S_SEND, S_RESULT, S_WAIT, S_OVER
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        ml_q, ml_qq, click, timeout;
  logic [7:0]  mouse_cell_q, mouse_cell_d;
  logic        cell_valid_q, cell_valid_d;
  logic        pick_ship_q, pick_ship_d;
  logic        local_ready_q, aim_en_q, shot_valid_q;
  logic [7:0]  shot_cell_q, shot_cell_d;
  logic [7:0]  my_hits_q, my_hits_d, my_inc;
  logic [7:0]  their_hits_q, their_hits_d, their_inc;
  logic        win_q, win_d, lose_q, lose_d;
  logic [3:0]  state_led_q, state_led_d;
  logic [11:0] dx, dy;
  logic        in_x, in_y;

  // Out-of-grid positions wrap in dx/dy, but cell_valid masks them.
  always_comb begin
    dx           = mouse_xpos - 12'(GRID_X0);
    dy           = mouse_ypos - 12'(GRID_Y0);
    in_x         = ({20'd0, mouse_xpos} >= 32'(GRID_X0)) && ({20'd0, mouse_xpos} < 32'(GRID_X0 + GRID_PIX));
    in_y         = ({20'd0, mouse_ypos} >= 32'(GRID_Y0)) && ({20'd0, mouse_ypos} < 32'(GRID_Y0 + GRID_PIX));
    cell_valid_d = in_x && in_y;
    mouse_cell_d = {4'(dy >> CELL_LOG2), 4'(dx >> CELL_LOG2)};
  end

  assign click     = ml_q && !ml_qq && cell_valid_q;
  assign cnt_inc   = cnt_q + 16'(frame_tick);
  assign timeout   = (TIMEOUT_FRAMES != 0) && (cnt_inc == 16'(TIMEOUT_FRAMES));
  assign my_inc    = (my_hits_q == 8'hFF) ? 8'hFF : my_hits_q + 8'd1;
  assign their_inc = (their_hits_q == 8'hFF) ? 8'hFF : their_hits_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    pick_ship_d  = 1'b0;
    shot_cell_d  = shot_cell_q;
    my_hits_d    = my_hits_q;
    their_hits_d = their_hits_q;
    win_d        = win_q;
    lose_d       = lose_q;
    unique case (state_q)
      S_PLACE: begin
        pick_ship_d = click;
        if (ship_count == 8'(SHIP_CELLS) && !mouse_left) state_d = S_SYNC;
      end
      S_SYNC: if (peer_ready) state_d = first_player ? S_WAIT : S_AIM;
      S_AIM: begin
        cnt_d = cnt_inc;
        if (click) begin
          state_d     = S_SEND;
          shot_cell_d = mouse_cell_q;
        end else if (timeout) begin
          state_d     = S_SEND;
          shot_cell_d = PASS;
        end
      end
      S_SEND: if (shot_valid_q && shot_ready) state_d = (shot_cell_q == PASS) ? S_WAIT : S_RESULT;
      S_RESULT: if (res_valid) begin
        if (res_hit) begin
          my_hits_d = my_inc;
          if (my_inc == 8'(SHIP_CELLS)) begin
            state_d = S_OVER;
            win_d   = 1'b1;
          end else state_d = (EXTRA_TURN != 0) ? S_AIM : S_WAIT;
        end else state_d = S_WAIT;
      end
      S_WAIT: if (enemy_valid) begin
        if (enemy_cell == PASS) state_d = S_AIM;
        else if (enemy_hit) begin
          their_hits_d = their_inc;
          if (their_inc == 8'(SHIP_CELLS)) begin
            state_d = S_OVER;
            lose_d  = 1'b1;
          end else state_d = (EXTRA_TURN != 0) ? S_WAIT : S_AIM;
        end else state_d = S_AIM;
      end
      S_OVER: if (restart) begin
        state_d      = S_PLACE;
        my_hits_d    = '0;
        their_hits_d = '0;
        win_d        = 1'b0;
        lose_d       = 1'b0;
      end
      default: state_d = S_PLACE;
    endcase

    unique case (state_d)
      S_PLACE:  state_led_d = 4'b0100;
      S_SYNC:   state_led_d = 4'b1100;
      S_AIM:    state_led_d = 4'b0001;
      S_SEND:   state_led_d = 4'b0011;
      S_RESULT: state_led_d = 4'b0101;
      S_WAIT:   state_led_d = 4'b0010;
      S_OVER:   state_led_d = win_d ? 4'b1111 : 4'b1000;
      default:  state_led_d = 4'b0100;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_PLACE;
      cnt_q         <= '0;
      ml_q          <= 1'b0;
      ml_qq         <= 1'b0;
      mouse_cell_q  <= '0;
      cell_valid_q  <= 1'b0;
      pick_ship_q   <= 1'b0;
      local_ready_q <= 1'b0;
      aim_en_q      <= 1'b0;
      shot_valid_q  <= 1'b0;
      shot_cell_q   <= '0;
      my_hits_q     <= '0;
      their_hits_q  <= '0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      state_led_q   <= 4'b0100;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ml_q          <= mouse_left;
      ml_qq         <= ml_q;
      mouse_cell_q  <= mouse_cell_d;
      cell_valid_q  <= cell_valid_d;
      pick_ship_q   <= pick_ship_d;
      local_ready_q <= (state_d != S_PLACE);
      aim_en_q      <= (state_d == S_AIM);
      shot_valid_q  <= (state_d == S_SEND);
      shot_cell_q   <= shot_cell_d;
      my_hits_q     <= my_hits_d;
      their_hits_q  <= their_hits_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      state_led_q   <= state_led_d;
    end
  end

  assign mouse_cell  = mouse_cell_q;
  assign cell_valid  = cell_valid_q;
  assign pick_ship   = pick_ship_q;
  assign local_ready = local_ready_q;
  assign aim_en      = aim_en_q;
  assign shot_valid  = shot_valid_q;
  assign shot_cell   = shot_cell_q;
  assign my_hits     = my_hits_q;
  assign their_hits  = their_hits_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign state_led   = state_led_q;

endmodule

// File: tb/tb_game_turn_ctl.sv
// Random game traffic into two controllers (EXTRA_TURN 0 and 1) sharing inputs, each checked against a game-rule model.
module tb_game_turn_ctl;
  localparam int SC = 3;
  localparam int TO = 3;
  localparam int NCYC = 8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, frame_tick, first_player, restart, mouse_left;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic [7:0]  ship_count, enemy_cell;
  logic        peer_ready, shot_ready, res_valid, res_hit, enemy_valid, enemy_hit;

  logic [7:0] o_mouse_cell [2];
  logic       o_cell_valid [2];
  logic       o_pick_ship [2];
  logic       o_local_ready [2];
  logic       o_aim_en [2];
  logic       o_shot_valid [2];
  logic [7:0] o_shot_cell [2];
  logic [7:0] o_my_hits [2];
  logic [7:0] o_their_hits [2];
  logic       o_win [2];
  logic       o_lose [2];
  logic [3:0] o_state_led [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    game_turn_ctl #(.SHIP_CELLS(SC), .EXTRA_TURN(g), .TIMEOUT_FRAMES(TO)) u_dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .first_player(first_player),
      .restart(restart), .mouse_left(mouse_left), .mouse_xpos(mouse_xpos),
      .mouse_ypos(mouse_ypos), .ship_count(ship_count), .peer_ready(peer_ready),
      .shot_ready(shot_ready), .res_valid(res_valid), .res_hit(res_hit),
      .enemy_valid(enemy_valid), .enemy_cell(enemy_cell), .enemy_hit(enemy_hit),
      .mouse_cell(o_mouse_cell[g]), .cell_valid(o_cell_valid[g]), .pick_ship(o_pick_ship[g]),
      .local_ready(o_local_ready[g]), .aim_en(o_aim_en[g]), .shot_valid(o_shot_valid[g]),
      .shot_cell(o_shot_cell[g]), .my_hits(o_my_hits[g]), .their_hits(o_their_hits[g]),
      .win(o_win[g]), .lose(o_lose[g]), .state_led(o_state_led[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Game-rule model: where each player is in the game, plus what the mouse looked like last cycle.
  typedef enum int {M_PLACE, M_SYNC, M_AIM, M_SEND, M_RESULT, M_WAIT, M_OVER} mode_e;
  mode_e m_mode [2];
  int    m_frames [2], m_mine [2], m_theirs [2], m_target [2];
  bit    m_won [2], m_lost [2], m_pick [2], m_after_rst [2];
  bit    p_ml1, p_ml2, p_cv;
  int    p_cell;

  function automatic int led_of(input mode_e m, input bit won);
    case (m)
      M_PLACE:  return 4;
      M_SYNC:   return 12;
      M_AIM:    return 1;
      M_SEND:   return 3;
      M_RESULT: return 5;
      M_WAIT:   return 2;
      default:  return won ? 15 : 8;
    endcase
  endfunction

  task automatic model_step();
    bit click;
    int x, y;
    click = p_ml1 && !p_ml2 && p_cv;
    for (int k = 0; k < 2; k++) begin
      m_pick[k] = 0;
      m_after_rst[k] = rst;
      if (rst) begin
        m_mode[k] = M_PLACE; m_mine[k] = 0; m_theirs[k] = 0;
        m_won[k] = 0; m_lost[k] = 0; m_target[k] = 0;
      end else begin
        case (m_mode[k])
          M_PLACE: begin
            m_pick[k] = click;
            if (int'(ship_count) == SC && !mouse_left) m_mode[k] = M_SYNC;
          end
          M_SYNC: if (peer_ready) m_mode[k] = first_player ? M_WAIT : M_AIM;
          M_AIM: begin
            m_frames[k] += int'(frame_tick);
            if (click) begin m_mode[k] = M_SEND; m_target[k] = p_cell; end
            else if (m_frames[k] == TO) begin m_mode[k] = M_SEND; m_target[k] = 255; end
          end
          M_SEND: if (shot_ready) m_mode[k] = (m_target[k] == 255) ? M_WAIT : M_RESULT;
          M_RESULT: if (res_valid) begin
            if (res_hit) begin
              m_mine[k] = (m_mine[k] < 255) ? m_mine[k] + 1 : 255;
              if (m_mine[k] == SC) begin m_mode[k] = M_OVER; m_won[k] = 1; end
              else m_mode[k] = (k == 1) ? M_AIM : M_WAIT;
            end else m_mode[k] = M_WAIT;
          end
          M_WAIT: if (enemy_valid) begin
            if (enemy_cell == 8'hFF) m_mode[k] = M_AIM;
            else if (enemy_hit) begin
              m_theirs[k] = (m_theirs[k] < 255) ? m_theirs[k] + 1 : 255;
              if (m_theirs[k] == SC) begin m_mode[k] = M_OVER; m_lost[k] = 1; end
              else m_mode[k] = (k == 1) ? M_WAIT : M_AIM;
            end else m_mode[k] = M_AIM;
          end
          default: if (restart) begin
            m_mode[k] = M_PLACE; m_mine[k] = 0; m_theirs[k] = 0; m_won[k] = 0; m_lost[k] = 0;
          end
        endcase
      end
      if (m_mode[k] != M_AIM) m_frames[k] = 0;
    end
    x = int'(mouse_xpos);
    y = int'(mouse_ypos);
    if (rst) begin
      p_ml1 = 0; p_ml2 = 0; p_cv = 0; p_cell = 0;
    end else begin
      p_ml2 = p_ml1;
      p_ml1 = mouse_left;
      p_cv  = (x >= 608) && (x < 608 + 320) && (y >= 193) && (y < 193 + 320);
      p_cell = p_cv ? ((y - 193) / 32) * 16 + (x - 608) / 32 : 0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      string s;
      s = $sformatf("d%0d", k);
      check_val({s, ".cell_valid"}, 16'(o_cell_valid[k]), 16'(p_cv));
      if (p_cv || m_after_rst[k]) check_val({s, ".mouse_cell"}, 16'(o_mouse_cell[k]), 16'(p_cell));
      check_val({s, ".pick_ship"}, 16'(o_pick_ship[k]), 16'(m_pick[k]));
      check_val({s, ".local_ready"}, 16'(o_local_ready[k]), 16'(m_mode[k] != M_PLACE));
      check_val({s, ".aim_en"}, 16'(o_aim_en[k]), 16'(m_mode[k] == M_AIM));
      check_val({s, ".shot_valid"}, 16'(o_shot_valid[k]), 16'(m_mode[k] == M_SEND));
      if (m_mode[k] == M_SEND || m_after_rst[k])
        check_val({s, ".shot_cell"}, 16'(o_shot_cell[k]), 16'(m_target[k]));
      check_val({s, ".my_hits"}, 16'(o_my_hits[k]), 16'(m_mine[k]));
      check_val({s, ".their_hits"}, 16'(o_their_hits[k]), 16'(m_theirs[k]));
      check_val({s, ".win"}, 16'(o_win[k]), 16'(m_won[k]));
      check_val({s, ".lose"}, 16'(o_lose[k]), 16'(m_lost[k]));
      check_val({s, ".state_led"}, 16'(o_state_led[k]), 16'(led_of(m_mode[k], m_won[k])));
    end
  endtask

  task automatic drive_random();
    int bx [6] = '{607, 608, 927, 928, 0, 4095};
    int by [6] = '{192, 193, 512, 513, 0, 4095};
    int r;
    bit in_send;
    in_send      = (m_mode[0] == M_SEND) || (m_mode[1] == M_SEND);
    rst          = in_send ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 499) == 0);
    frame_tick   = ($urandom_range(0, 2) == 0);
    first_player = $urandom_range(0, 1) == 1;
    restart      = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 2) == 0) mouse_left = ~mouse_left;
    if ($urandom_range(0, 3) == 0) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        mouse_xpos = 12'($urandom_range(0, 4095));
        mouse_ypos = 12'($urandom_range(0, 4095));
      end else if (r == 1) begin
        mouse_xpos = 12'(bx[$urandom_range(0, 5)]);
        mouse_ypos = 12'(by[$urandom_range(0, 5)]);
      end else begin
        mouse_xpos = 12'($urandom_range(608, 927));
        mouse_ypos = 12'($urandom_range(193, 512));
      end
    end
    ship_count  = ($urandom_range(0, 1) == 0) ? 8'(SC) : 8'($urandom_range(0, SC + 2));
    peer_ready  = ($urandom_range(0, 3) == 0);
    shot_ready  = ($urandom_range(0, 2) == 0);
    res_valid   = ($urandom_range(0, 3) == 0);
    res_hit     = ($urandom_range(0, 2) != 0);
    enemy_valid = ($urandom_range(0, 3) == 0);
    enemy_cell  = ($urandom_range(0, 4) == 0) ? 8'hFF
                : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    enemy_hit   = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; first_player = 1'b0; restart = 1'b0; mouse_left = 1'b0;
    mouse_xpos = 12'd620; mouse_ypos = 12'd200; ship_count = 8'd0; peer_ready = 1'b0;
    shot_ready = 1'b0; res_valid = 1'b0; res_hit = 1'b0; enemy_valid = 1'b0;
    enemy_cell = 8'd0; enemy_hit = 1'b0;
    for (int k = 0; k < 2; k++) m_frames[k] = 0;
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      check_outputs();
      drive_random();
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
